mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-ported memory between the instruction-fetch unit and the load/store unit.
- Sequences one outstanding memory transaction at a time.
- Data accesses have priority; a streak limit keeps fetch from starving.
- A timeout watchdog returns an error if memory never acknowledges.
- Sits between the cpu core's fetch/LSU stages and the memory model instantiated under testbench.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables = DATA_W/8)
- MAX_DSTREAK, 4, consecutive data grants allowed while fetch waits (>=1)
- TIMEOUT_CYCLES, 64, cycles in BUSY without mem_ack before abort (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  one-cycle grant pulse to fetch
- i_rvalid  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_W  fetch read data, valid with i_rvalid
- i_err  out  1  fetch timed out, valid with i_rvalid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant pulse to LSU
- d_rvalid  out  1  one-cycle data completion pulse (loads and stores)
- d_rdata  out  DATA_W  load data
- d_err  out  1  data timed out, valid with d_rvalid
- mem_req  out  1  memory request, held until mem_ack or abort
- mem_we  out  1  memory write
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion, single cycle
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- All outputs are registered.
- Reset (rst==0 at posedge): state IDLE, every output 0, streak and timeout counters 0.
  - Reset mid-transaction drops mem_req immediately.
  - No rvalid is issued for the aborted request.
  - An mem_ack arriving after reset is ignored.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, edge with any request pending:
  - Pick the winner; go to BUSY_I or BUSY_D.
  - Load mem_* from the winner's inputs (fetch: mem_we=0, mem_be=all ones, mem_wdata=0).
  - Set mem_req=1 and pulse the winner's gnt for exactly one cycle.
  - IDLE with no request: hold state, mem_req=0.
- Arbitration:
  - Only d_req: data wins. Only i_req: fetch wins.
  - Both: data wins unless dstreak==MAX_DSTREAK, then fetch wins.
- dstreak:
  - Increments, saturating at MAX_DSTREAK, on a data grant made while i_req=1.
  - Clears to 0 on any fetch grant, and on a data grant made with i_req=0.
- BUSY_x with mem_ack=1:
  - Next cycle: x_rvalid=1 for one cycle, x_rdata=mem_rdata (0 for stores), x_err=0.
  - mem_req=0; state returns to IDLE.
- Latency:
  - Request seen at edge T: gnt and mem_req high in cycle T+1.
  - mem_ack in cycle T+k (k>=1): rvalid in cycle T+k+1.
  - Next grant no earlier than cycle T+k+2, i.e. one idle cycle between transactions.
- Timeout:
  - Counter clears on entering BUSY and increments each BUSY cycle without mem_ack.
  - On reaching TIMEOUT_CYCLES, next cycle: mem_req=0, x_rvalid=1, x_err=1, x_rdata=0; state returns to IDLE.
  - mem_ack in the same cycle the counter reaches the limit: ack wins, no error.
  - Stray mem_ack while IDLE is ignored.
- mem_* address/data stay stable while mem_req=1; requester input changes after gnt have no effect.
- rdata/err hold their last value between rvalid pulses; only the rvalid pulse qualifies them.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - FSM state enum arb_state_t {IDLE, BUSY_I, BUSY_D}
  - default ADDR_W/DATA_W constants
  - requester id type
- One natural sub-module: arb_watchdog (timeout counter with clear, enable, expired outputs).
- Arbitration and the streak counter stay in the top module.

Test Plan:
- Fetch only, i_addr=0x100, mem_ack 2 cycles after mem_req -> i_gnt in cycle T+1, mem_addr=0x100, i_rvalid with i_rdata=mem_rdata at T+3, d_* outputs stay 0.
- i_req and d_req held continuously, zero-wait ack (MAX_DSTREAK=4) -> grant order D,D,D,D,I,D,D,D,D,I.
- Store d_addr=0x2000, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_rvalid=1 with d_rdata=0.
- Memory never acks, TIMEOUT_CYCLES=8 -> mem_req high for 8 cycles then low, d_rvalid=1 with d_err=1, d_rdata=0; a later stray mem_ack produces no rvalid.
- rst driven low two cycles into a BUSY_I transaction -> mem_req, i_gnt, i_rvalid all 0 next cycle; ack during reset ignored; after release a fresh i_req is granted normally.
- mem_ack in the exact cycle the timeout counter hits the limit -> normal completion, err=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory-port slice: arbiter FSM states, bus width defaults, requester id.
package cpu_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle watchdog: clr restarts, en counts one cycle; expired is combinational and flags the
// enabled cycle that would bring the count to TIMEOUT_CYCLES.
module arb_watchdog
    import cpu_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Firing one count early lets the abort land exactly TIMEOUT_CYCLES busy cycles after grant.
    assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter of fetch and LSU onto one memory port; data priority with a fetch
// anti-starvation streak limit. Grant 1 cycle after request, rvalid 1 cycle after mem_ack or timeout.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_DSTREAK    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_DSTREAK + 1);

    arb_state_t          state_q, state_d;
    logic [SW-1:0]       dstreak_q, dstreak_d;
    logic                i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic                i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                i_err_q, i_err_d, d_err_q, d_err_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                grant;
    logic                busy;
    logic                expired;
    req_id_t             winner;
    logic [DATA_W-1:0]   resp_dat;

    assign busy     = (state_q != IDLE);
    assign winner   = (i_req && (!d_req || (dstreak_q == SW'(MAX_DSTREAK)))) ? REQ_I : REQ_D;
    // Stores and timeouts both return zero data.
    assign resp_dat = (mem_ack && !mem_we_q) ? mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        dstreak_d   = dstreak_q;
        grant       = 1'b0;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_err_d     = i_err_q;
        d_err_d     = d_err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant     = 1'b1;
                    mem_req_d = 1'b1;
                    if (winner == REQ_I) begin
                        state_d     = BUSY_I;
                        i_gnt_d     = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_be_d    = {BE_W{1'b1}};
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        dstreak_d   = '0;
                    end else begin
                        state_d     = BUSY_D;
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (!i_req) begin
                            dstreak_d = '0;
                        end else if (dstreak_q != SW'(MAX_DSTREAK)) begin
                            dstreak_d = dstreak_q + SW'(1);
                        end
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || expired) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = resp_dat;
                        i_err_d    = !mem_ack;
                    end else begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = resp_dat;
                        d_err_d    = !mem_ack;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant),
        .en     (busy && !mem_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            dstreak_q   <= '0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dstreak_q   <= dstreak_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign i_gnt     = i_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic scored against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TMO  = 8;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_be = '0;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, mem_req, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    // model / scratch state
    byte         ord[$];
    string       exp_ord = "DDDDIDDDDI";
    byte         got;
    int          n;
    bit          m_busy, m_fetch, m_we, done;
    int          m_bc, m_streak;
    logic [31:0] m_addr, m_wdata, e_rdat;
    logic [3:0]  m_be;
    bit          e_ig, e_dg, e_irv, e_drv, e_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_i_gnt", i_gnt, 0);      chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_req", mem_req, 0);  chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0); chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;

        // fetch only, ack two cycles after mem_req
        i_req = 1'b1; i_addr = 32'h100;
        tick();
        chk("f_i_gnt", i_gnt, 1);        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h100); chk("f_mem_we", mem_we, 0);
        chk("f_mem_be", mem_be, 4'hf);   chk("f_d_gnt", d_gnt, 0);
        i_req = 1'b0;
        tick();
        chk("f_gnt_pulse", i_gnt, 0);    chk("f_mem_req_hold", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk("f_i_rvalid", i_rvalid, 1);  chk("f_i_rdata", i_rdata, 32'hCAFEF00D);
        chk("f_i_err", i_err, 0);        chk("f_mem_req_drop", mem_req, 0);
        chk("f_d_rvalid", d_rvalid, 0);
        tick();
        chk("f_rvalid_pulse", i_rvalid, 0); chk("f_rdata_hold", i_rdata, 32'hCAFEF00D);

        // both requesting continuously, zero-wait ack
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h200; d_addr = 32'h300;
        for (int c = 0; c < 60 && ord.size() < 10; c++) begin
            tick();
            if (i_gnt) ord.push_back("I");
            if (d_gnt) ord.push_back("D");
            mem_ack = mem_req;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("order_len", ord.size(), 10);
        for (int i = 0; i < 10; i++) begin
            got = (i < ord.size()) ? ord[i] : 8'h3F;
            chk($sformatf("order_%0d", i), got, exp_ord[i]);
        end

        // store with partial byte enables; inputs scrambled after grant
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        tick();
        chk("st_d_gnt", d_gnt, 1);       chk("st_mem_we", mem_we, 1);
        chk("st_mem_be", mem_be, 4'b0011); chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_mem_addr", mem_addr, 32'h2000);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hf; d_addr = 32'hFFFF0000; d_wdata = 32'h0;
        tick();
        chk("st_hold_addr", mem_addr, 32'h2000); chk("st_hold_wdata", mem_wdata, 32'hDEADBEEF);
        chk("st_hold_we", mem_we, 1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        chk("st_d_rvalid", d_rvalid, 1); chk("st_d_rdata", d_rdata, 0);
        chk("st_d_err", d_err, 0);
        tick();

        // memory never acks
        d_req = 1'b1; d_addr = 32'h3000;
        tick();
        d_req = 1'b0;
        n = mem_req ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_req) n++;
            else break;
        end
        chk("to_req_cycles", n, TMO);    chk("to_d_rvalid", d_rvalid, 1);
        chk("to_d_err", d_err, 1);       chk("to_d_rdata", d_rdata, 0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("stray_d_rvalid", d_rvalid, 0); chk("stray_i_rvalid", i_rvalid, 0);
        chk("stray_mem_req", mem_req, 0);

        // ack lands in the last allowed busy cycle
        d_req = 1'b1; d_addr = 32'h4000;
        tick();
        d_req = 1'b0;
        for (int c = 0; c < TMO - 1; c++) tick();
        chk("lim_mem_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000A5A5;
        tick();
        mem_ack = 1'b0;
        chk("lim_d_rvalid", d_rvalid, 1); chk("lim_d_err", d_err, 0);
        chk("lim_d_rdata", d_rdata, 32'h0000A5A5);
        tick();

        // reset during a fetch transaction
        i_req = 1'b1; i_addr = 32'h300;
        tick();
        i_req = 1'b0;
        tick();
        chk("rb_mem_req", mem_req, 1);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        chk("rb_mem_req_drop", mem_req, 0); chk("rb_i_gnt", i_gnt, 0);
        chk("rb_i_rvalid", i_rvalid, 0);
        tick();
        rst = 1'b1; mem_ack = 1'b0;
        tick();
        chk("rb_no_rvalid", i_rvalid, 0); chk("rb_idle", mem_req, 0);
        i_req = 1'b1; i_addr = 32'h400;
        tick();
        chk("rb_regrant", i_gnt, 1);     chk("rb_regrant_addr", mem_addr, 32'h400);
        i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h000055AA;
        tick();
        mem_ack = 1'b0;
        chk("rb_rvalid", i_rvalid, 1);   chk("rb_rdata", i_rdata, 32'h000055AA);

        // randomized traffic against the transaction model
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        rst = 1'b1;
        m_busy = 0; m_streak = 0; m_bc = 0; m_fetch = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_err = 0; e_rdat = '0; done = 0;
            if (m_busy) begin
                m_bc++;
                if (mem_ack) begin
                    e_rdat = m_we ? 32'h0 : mem_rdata; done = 1;
                end else if (m_bc == TMO) begin
                    e_err = 1; done = 1;
                end
                if (done) begin
                    m_busy = 0;
                    if (m_fetch) e_irv = 1; else e_drv = 1;
                end
            end else if (i_req || d_req) begin
                m_fetch = i_req && (!d_req || m_streak == MAXS);
                if (m_fetch) begin
                    e_ig = 1; m_addr = i_addr; m_we = 0; m_be = 4'hf; m_wdata = 0; m_streak = 0;
                end else begin
                    e_dg = 1; m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
                    m_streak = i_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                end
                m_busy = 1; m_bc = 0;
            end
            tick();
            chk("r_i_gnt", i_gnt, e_ig);       chk("r_d_gnt", d_gnt, e_dg);
            chk("r_i_rvalid", i_rvalid, e_irv); chk("r_d_rvalid", d_rvalid, e_drv);
            chk("r_mem_req", mem_req, m_busy);
            if (e_irv) begin
                chk("r_i_rdata", i_rdata, e_rdat); chk("r_i_err", i_err, e_err);
            end
            if (e_drv) begin
                chk("r_d_rdata", d_rdata, e_rdat); chk("r_d_err", d_err, e_err);
            end
            if (m_busy) begin
                chk("r_mem_addr", mem_addr, m_addr); chk("r_mem_we", mem_we, m_we);
                chk("r_mem_be", mem_be, m_be);       chk("r_mem_wdata", mem_wdata, m_wdata);
            end
            if (i_gnt) begin
                i_req = 1'b0; i_addr = $urandom;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_gnt) begin
                d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom;
                d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(0, 15));
            end
            mem_rdata = $urandom;
            mem_ack = mem_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
